// File: rtl/cache_refill_nway_pkg.sv
// Shared encodings for the N-way cache line refill engine: AXI burst/response codes and FSM states.
// Optional build macro used by the engine: CACHE_REFILL_CWF_EN (critical-word-first refill).
package cache_refill_nway_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } refill_state_e;

  function automatic logic resp_is_okay(input logic [1:0] resp);
    return resp == RESP_OKAY;
  endfunction

endpackage

// File: rtl/cache_refill_linebuf.sv
// Line buffer for the refill engine: BEATS words of DATA_W bits, one slot written per cycle,
// all slots visible at once as a flat vector (word k at [k*DATA_W +: DATA_W]).
module cache_refill_linebuf
  import cache_refill_nway_pkg::*;
#(
  parameter int BEATS  = 4,
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en_i,
  input  logic [OFF_W-1:0]        wr_slot_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  output logic [BEATS*DATA_W-1:0] line_o
);

  logic [BEATS-1:0][DATA_W-1:0] mem_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_slot_i] <= wr_data_i;
    end
  end

  assign line_o = mem_q;

endmodule

// File: rtl/cache_refill_nway.sv
// Line refill engine for an N-way set-associative cache: one AXI4 read burst per miss, then a single-cycle
// way write. Define CACHE_REFILL_CWF_EN for critical-word-first (WRAP burst plus early word_valid/word_data).
module cache_refill_nway
  import cache_refill_nway_pkg::*;
#(
  parameter int WAYS    = 2,
  parameter int BEATS   = 4,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 22,
  parameter int ID_W    = 4,
  parameter int AXI_ID  = 0,
  localparam int WAY_W  = $clog2(WAYS),
  localparam int OFF_W  = $clog2(BEATS),
  localparam int BYTE_W = $clog2(DATA_W/8),
  localparam int ADDR_W = TAG_W + INDEX_W + OFF_W + BYTE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [INDEX_W-1:0]      req_index,
  input  logic [TAG_W-1:0]        req_tag,
  input  logic [WAY_W-1:0]        req_way,
  input  logic [OFF_W-1:0]        req_offset,
  output logic [ADDR_W-1:0]       araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [ID_W-1:0]         arid,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_W-1:0]       rdata,
  input  logic [ID_W-1:0]         rid,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [BEATS*DATA_W-1:0] rsp_data,
  output logic [WAYS-1:0]         way_wen,
  output logic [INDEX_W-1:0]      wr_index,
  output logic [TAG_W-1:0]        wr_tag,
  output logic                    wr_valid
`ifdef CACHE_REFILL_CWF_EN
  ,
  output logic                    word_valid,
  output logic [DATA_W-1:0]       word_data
`endif
);

  localparam logic [ID_W-1:0]  ID_VAL   = ID_W'(AXI_ID);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BEATS - 1);

  refill_state_e       state_q;
  logic [INDEX_W-1:0]  index_q;
  logic [TAG_W-1:0]    tag_q;
  logic [WAY_W-1:0]    way_q;
  logic [OFF_W-1:0]    start_q;
  logic [OFF_W-1:0]    cnt_q;
  logic                over_q;
  logic                err_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [WAYS-1:0]     way_wen_q;
  logic                wr_valid_q;

  logic                beat_hit;
  logic                beat_store;
  logic                beat_err;
  logic                err_d;
  logic [OFF_W-1:0]    slot;
  logic [OFF_W-1:0]    start_d;

  // Only beats carrying our ID count; once the counter has wrapped, beats are errors and are not stored.
  assign beat_hit   = rvalid & rready_q & (rid == ID_VAL);
  assign beat_store = beat_hit & ~over_q;
  assign beat_err   = ~resp_is_okay(rresp) | over_q | (rlast & (cnt_q != LAST_OFF));
  assign err_d      = err_q | (beat_hit & beat_err);
  assign slot       = start_q + cnt_q;

`ifdef CACHE_REFILL_CWF_EN
  assign start_d = req_offset;
  assign arburst = BURST_WRAP;
`else
  logic unused_offset;
  assign unused_offset = ^req_offset;
  assign start_d = '0;
  assign arburst = BURST_INCR;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      tag_q       <= '0;
      way_q       <= '0;
      start_q     <= '0;
      cnt_q       <= '0;
      over_q      <= 1'b0;
      err_q       <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      way_wen_q   <= '0;
      wr_valid_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      way_wen_q   <= '0;
      wr_valid_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            index_q   <= req_index;
            tag_q     <= req_tag;
            way_q     <= req_way;
            start_q   <= start_d;
            cnt_q     <= '0;
            over_q    <= 1'b0;
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
            arvalid_q <= 1'b1;
            state_q   <= ST_AR;
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD;
          end
        end
        ST_RD: begin
          if (beat_hit) begin
            err_q <= err_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_OFF) begin
              over_q <= 1'b1;
            end
            // A failed refill still strobes the way, but with valid=0 so the stale line is invalidated.
            if (rlast) begin
              rready_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= err_d;
              way_wen_q   <= WAYS'(1) << way_q;
              wr_valid_q  <= ~err_d;
              state_q     <= ST_WR;
            end
          end
        end
        ST_WR: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_REFILL_CWF_EN
  logic              word_valid_q;
  logic [DATA_W-1:0] word_data_q;

  // The critical word is the first counted beat; forward it to the core as soon as it arrives clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
    end else begin
      word_valid_q <= beat_store & (cnt_q == '0) & resp_is_okay(rresp);
      if (beat_store & (cnt_q == '0)) begin
        word_data_q <= rdata;
      end
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
`endif

  cache_refill_linebuf #(
    .BEATS  (BEATS),
    .DATA_W (DATA_W)
  ) u_linebuf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (beat_store),
    .wr_slot_i (slot),
    .wr_data_i (rdata),
    .line_o    (rsp_data)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign araddr    = {tag_q, index_q, start_q, {BYTE_W{1'b0}}};
  assign arlen     = 8'(BEATS - 1);
  assign arsize    = 3'(BYTE_W);
  assign arid      = ID_VAL;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign way_wen   = way_wen_q;
  assign wr_index  = index_q;
  assign wr_tag    = tag_q;
  assign wr_valid  = wr_valid_q;

endmodule

// File: tb/tb_cache_refill_nway.sv
// Self-checking bench for cache_refill_nway (WAYS=4, BEATS=4) in the default build (CACHE_REFILL_CWF_EN undefined).
// Expected refill results come from a beat-list model of the refill rules kept in this file.
module tb_cache_refill_nway;

  localparam int WAYS = 4, BEATS = 4, DATA_W = 32, INDEX_W = 6, TAG_W = 22, ID_W = 4, AXI_ID = 0;
  localparam int LINE_W = BEATS * DATA_W;

  logic clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [INDEX_W-1:0] req_index = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [1:0] req_way = '0, req_offset = '0;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [ID_W-1:0] arid;
  logic arvalid, arready = 1'b0;
  logic [DATA_W-1:0] rdata = '0;
  logic [ID_W-1:0] rid = '0;
  logic [1:0] rresp = '0;
  logic rlast = 1'b0, rvalid = 1'b0, rready;
  logic rsp_valid, rsp_err, wr_valid;
  logic [LINE_W-1:0] rsp_data;
  logic [WAYS-1:0] way_wen;
  logic [INDEX_W-1:0] wr_index;
  logic [TAG_W-1:0] wr_tag;

  int errors = 0, checks = 0;
  int ar_hs = 0, rsp_cnt = 0, wen_cnt = 0;

  // Beat list for the next transaction and the model's view of it
  logic [DATA_W-1:0] q_data[$];
  logic [ID_W-1:0] q_id[$];
  logic [1:0] q_resp[$];
  bit q_last[$];
  bit exp_err;
  logic [LINE_W-1:0] exp_line;
  int exp_end;

  // Values captured by the driver during a transaction
  logic [31:0] cap_araddr;
  logic [7:0] cap_arlen;
  logic [2:0] cap_arsize;
  logic [1:0] cap_arburst;
  logic [ID_W-1:0] cap_arid;
  bit ar_bad, cap_busy_ready, got_rsp;
  logic cap_err, cap_wvalid;
  logic [WAYS-1:0] cap_wen;
  logic [INDEX_W-1:0] cap_idx;
  logic [TAG_W-1:0] cap_tag;
  logic [LINE_W-1:0] cap_data;
  int cap_lat;
  logic post_rsp, post_ready;
  logic [WAYS-1:0] post_wen;

  cache_refill_nway #(
    .WAYS(WAYS), .BEATS(BEATS), .DATA_W(DATA_W), .INDEX_W(INDEX_W),
    .TAG_W(TAG_W), .ID_W(ID_W), .AXI_ID(AXI_ID)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_tag(req_tag),
    .req_way(req_way), .req_offset(req_offset),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data), .way_wen(way_wen),
    .wr_index(wr_index), .wr_tag(wr_tag), .wr_valid(wr_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arvalid && arready) ar_hs <= ar_hs + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (way_wen != '0) wen_cnt <= wen_cnt + 1;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    q_data.delete(); q_id.delete(); q_resp.delete(); q_last.delete();
  endtask

  task automatic add_beat(input logic [DATA_W-1:0] d, input logic [ID_W-1:0] id,
                          input logic [1:0] resp, input bit last);
    q_data.push_back(d); q_id.push_back(id); q_resp.push_back(resp); q_last.push_back(last);
  endtask

  // Refill rules: only our ID counts, k-th counted beat lands in word k, any non-OKAY, surplus beat
  // or misplaced rlast marks the line bad, and the first counted rlast ends the burst.
  task automatic run_model();
    int k;
    k = 0;
    exp_err = 1'b0;
    exp_line = '0;
    exp_end = q_data.size() - 1;
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_id[i] != ID_W'(AXI_ID)) continue;
      if (q_resp[i] != 2'b00) exp_err = 1'b1;
      if (k < BEATS) exp_line[k*DATA_W +: DATA_W] = q_data[i];
      else exp_err = 1'b1;
      if (q_last[i]) begin
        if (k != BEATS - 1) exp_err = 1'b1;
        exp_end = i;
        break;
      end
      k++;
    end
  endtask

  task automatic send_req(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                          input logic [1:0] way);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin cycle(); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("[TB] FAIL req_ready_wait: got %0b required 1 within 50 cycles", req_ready);
    end
    req_valid = 1'b1; req_index = idx; req_tag = tag; req_way = way;
    req_offset = 2'($urandom_range(0, 3));
    cycle();
    req_valid = 1'b0;
    cap_busy_ready = req_ready;
  endtask

  task automatic do_ar(input int delay);
    cap_araddr = araddr; cap_arlen = arlen; cap_arsize = arsize;
    cap_arburst = arburst; cap_arid = arid;
    ar_bad = !arvalid;
    for (int d = 0; d < delay; d++) begin
      cycle();
      if (!arvalid || araddr !== cap_araddr) ar_bad = 1'b1;
    end
    arready = 1'b1;
    cycle();
    arready = 1'b0;
  endtask

  task automatic send_beats(input int upto, input bit gaps);
    for (int i = 0; i <= upto; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cycle();
      rvalid = 1'b1; rdata = q_data[i]; rid = q_id[i]; rresp = q_resp[i]; rlast = q_last[i];
      cycle();
      rvalid = 1'b0; rlast = 1'b0;
    end
  endtask

  task automatic wait_rsp();
    cap_lat = 0;
    while (!rsp_valid && cap_lat < 40) begin cycle(); cap_lat++; end
    got_rsp = rsp_valid;
    if (!got_rsp) begin
      checks++; errors++;
      $display("[TB] FAIL rsp_wait: got rsp_valid=%0b required 1 within 40 cycles", rsp_valid);
    end
    cap_err = rsp_err; cap_wen = way_wen; cap_wvalid = wr_valid;
    cap_idx = wr_index; cap_tag = wr_tag; cap_data = rsp_data;
    cycle();
    post_rsp = rsp_valid; post_ready = req_ready; post_wen = way_wen;
  endtask

  task automatic run_txn(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                         input logic [1:0] way, input int delay, input bit gaps);
    run_model();
    send_req(idx, tag, way);
    do_ar(delay);
    send_beats(exp_end, gaps);
    wait_rsp();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %0b required 1", req_ready); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_arvalid: got %0b required 0", arvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("[TB] FAIL reset_rready: got %0b required 0", rready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %0b required 0", rsp_valid); end
    checks++; if (way_wen !== 4'b0) begin errors++; $display("[TB] FAIL reset_way_wen: got %b required 0000", way_wen); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err: got %0b required 0", rsp_err); end
    @(negedge clk);
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_clean_refill();
    int ar0, rsp0;
    ar0 = ar_hs; rsp0 = rsp_cnt;
    clear_beats();
    add_beat(32'h11, 4'd0, 2'b00, 1'b0);
    add_beat(32'h22, 4'd0, 2'b00, 1'b0);
    add_beat(32'h33, 4'd0, 2'b00, 1'b0);
    add_beat(32'h44, 4'd0, 2'b00, 1'b1);
    run_txn(6'd5, 22'h3A, 2'd2, 0, 1'b0);
    checks++; if (cap_araddr !== {22'h3A, 6'd5, 4'b0}) begin errors++; $display("[TB] FAIL clean_araddr: got %h required %h", cap_araddr, {22'h3A, 6'd5, 4'b0}); end
    checks++; if (cap_arlen !== 8'd3) begin errors++; $display("[TB] FAIL clean_arlen: got %0d required 3", cap_arlen); end
    checks++; if (cap_arsize !== 3'd2) begin errors++; $display("[TB] FAIL clean_arsize: got %0d required 2", cap_arsize); end
    checks++; if (cap_arburst !== 2'b01) begin errors++; $display("[TB] FAIL clean_arburst: got %b required 01", cap_arburst); end
    checks++; if (cap_arid !== 4'd0) begin errors++; $display("[TB] FAIL clean_arid: got %0d required 0", cap_arid); end
    checks++; if (ar_bad !== 1'b0) begin errors++; $display("[TB] FAIL clean_arvalid_early: got bad=%0b required 0", ar_bad); end
    checks++; if (cap_busy_ready !== 1'b0) begin errors++; $display("[TB] FAIL clean_busy_ready: got %0b required 0", cap_busy_ready); end
    checks++; if (cap_lat !== 0) begin errors++; $display("[TB] FAIL clean_latency: got %0d extra cycles required 0", cap_lat); end
    checks++; if (cap_err !== 1'b0) begin errors++; $display("[TB] FAIL clean_rsp_err: got %0b required 0", cap_err); end
    checks++; if (cap_wen !== 4'b0100) begin errors++; $display("[TB] FAIL clean_way_wen: got %b required 0100", cap_wen); end
    checks++; if (cap_wvalid !== 1'b1) begin errors++; $display("[TB] FAIL clean_wr_valid: got %0b required 1", cap_wvalid); end
    checks++; if (cap_data !== 128'h00000044_00000033_00000022_00000011) begin errors++; $display("[TB] FAIL clean_rsp_data: got %h required %h", cap_data, 128'h00000044_00000033_00000022_00000011); end
    checks++; if (cap_idx !== 6'd5 || cap_tag !== 22'h3A) begin errors++; $display("[TB] FAIL clean_wr_addr: got idx=%0d tag=%h required idx=5 tag=3a", cap_idx, cap_tag); end
    checks++; if (post_rsp !== 1'b0 || post_wen !== 4'b0 || post_ready !== 1'b1) begin errors++; $display("[TB] FAIL clean_pulse_end: got rsp=%0b wen=%b ready=%0b required 0 0000 1", post_rsp, post_wen, post_ready); end
    checks++; if (ar_hs - ar0 !== 1 || rsp_cnt - rsp0 !== 1) begin errors++; $display("[TB] FAIL clean_counts: got ar=%0d rsp=%0d required 1 1", ar_hs - ar0, rsp_cnt - rsp0); end
  endtask

  task automatic test_ar_stall();
    int ar0;
    ar0 = ar_hs;
    clear_beats();
    for (int k = 0; k < BEATS; k++) add_beat($urandom, 4'd0, 2'b00, k == BEATS - 1);
    run_txn(6'd17, 22'h12345, 2'd1, 5, 1'b1);
    checks++; if (ar_bad !== 1'b0) begin errors++; $display("[TB] FAIL stall_ar_stable: got bad=%0b required 0", ar_bad); end
    checks++; if (ar_hs - ar0 !== 1) begin errors++; $display("[TB] FAIL stall_ar_handshakes: got %0d required 1", ar_hs - ar0); end
    checks++; if (cap_data !== exp_line || cap_err !== 1'b0) begin errors++; $display("[TB] FAIL stall_result: got err=%0b data=%h required err=0 data=%h", cap_err, cap_data, exp_line); end
  endtask

  task automatic test_slverr();
    clear_beats();
    for (int k = 0; k < BEATS; k++) add_beat($urandom, 4'd0, (k == 2) ? 2'b10 : 2'b00, k == BEATS - 1);
    run_txn(6'd9, 22'h2F0F0, 2'd3, 1, 1'b0);
    checks++; if (cap_err !== 1'b1) begin errors++; $display("[TB] FAIL slverr_rsp_err: got %0b required 1", cap_err); end
    checks++; if (cap_wen !== 4'b1000) begin errors++; $display("[TB] FAIL slverr_way_wen: got %b required 1000", cap_wen); end
    checks++; if (cap_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL slverr_wr_valid: got %0b required 0", cap_wvalid); end
  endtask

  task automatic test_early_rlast();
    clear_beats();
    for (int k = 0; k < 3; k++) add_beat($urandom, 4'd0, 2'b00, k == 2);
    run_txn(6'd40, 22'h00ABC, 2'd0, 0, 1'b0);
    checks++; if (cap_lat !== 0 || cap_err !== 1'b1) begin errors++; $display("[TB] FAIL early_rlast_err: got lat=%0d err=%0b required 0 1", cap_lat, cap_err); end
    checks++; if (cap_wvalid !== 1'b0 || cap_wen !== 4'b0001) begin errors++; $display("[TB] FAIL early_rlast_write: got wv=%0b wen=%b required 0 0001", cap_wvalid, cap_wen); end
    checks++; if (post_ready !== 1'b1) begin errors++; $display("[TB] FAIL early_rlast_idle: got req_ready=%0b required 1", post_ready); end
  endtask

  task automatic test_overrun();
    clear_beats();
    for (int k = 0; k < 5; k++) add_beat($urandom, 4'd0, 2'b00, k == 4);
    run_txn(6'd1, 22'h3FFFFF, 2'd2, 0, 1'b0);
    checks++; if (cap_err !== 1'b1 || cap_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL overrun_err: got err=%0b wv=%0b required 1 0", cap_err, cap_wvalid); end
  endtask

  task automatic test_foreign_id();
    clear_beats();
    for (int k = 0; k < BEATS; k++) begin
      add_beat($urandom, 4'(k + 3), 2'b10, 1'b1);
      add_beat(32'hA0 + k, 4'd0, 2'b00, k == BEATS - 1);
    end
    run_txn(6'd33, 22'h15555, 2'd1, 2, 1'b1);
    checks++; if (cap_err !== 1'b0 || cap_wvalid !== 1'b1) begin errors++; $display("[TB] FAIL foreign_err: got err=%0b wv=%0b required 0 1", cap_err, cap_wvalid); end
    checks++; if (cap_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin errors++; $display("[TB] FAIL foreign_data: got %h required %h", cap_data, 128'h000000A3_000000A2_000000A1_000000A0); end
  endtask

  task automatic test_reset_mid();
    int wen0, rsp0;
    wen0 = wen_cnt; rsp0 = rsp_cnt;
    clear_beats();
    for (int k = 0; k < BEATS; k++) add_beat($urandom, 4'd0, 2'b00, k == BEATS - 1);
    send_req(6'd7, 22'h777, 2'd3);
    do_ar(0);
    send_beats(1, 1'b0);
    #2 reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || rready !== 1'b0 || arvalid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_idle: got ready=%0b rready=%0b arvalid=%0b required 1 0 0", req_ready, rready, arvalid); end
    @(negedge clk);
    reset = 1'b1;
    cycle();
    rvalid = 1'b1; rdata = 32'hDEAD; rid = 4'd0; rresp = 2'b00; rlast = 1'b1;
    repeat (2) cycle();
    rvalid = 1'b0; rlast = 1'b0;
    repeat (3) cycle();
    checks++; if (wen_cnt - wen0 !== 0 || rsp_cnt - rsp0 !== 0) begin errors++; $display("[TB] FAIL midreset_no_write: got wen=%0d rsp=%0d required 0 0", wen_cnt - wen0, rsp_cnt - rsp0); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %0b required 1", req_ready); end
  endtask

  task automatic test_random();
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0] way;
    int n;
    for (int it = 0; it < 25; it++) begin
      idx = 6'($urandom_range(0, 63));
      tag = 22'($urandom);
      way = 2'($urandom_range(0, 3));
      n = BEATS;
      case ($urandom_range(0, 9))
        0: n = BEATS - 1;
        1: n = BEATS + 1;
        default: n = BEATS;
      endcase
      clear_beats();
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) add_beat($urandom, 4'($urandom_range(1, 15)), 2'($urandom), 1'($urandom));
        add_beat($urandom, 4'd0, ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, k == n - 1);
      end
      run_txn(idx, tag, way, $urandom_range(0, 3), 1'b1);
      checks++; if (cap_araddr !== {tag, idx, 4'b0}) begin errors++; $display("[TB] FAIL rand_araddr[%0d]: got %h required %h", it, cap_araddr, {tag, idx, 4'b0}); end
      checks++; if (cap_err !== exp_err || cap_wvalid !== !exp_err) begin errors++; $display("[TB] FAIL rand_err[%0d]: got err=%0b wv=%0b required err=%0b", it, cap_err, cap_wvalid, exp_err); end
      checks++; if (cap_wen !== (4'b1 << way) || cap_lat !== 0) begin errors++; $display("[TB] FAIL rand_wen[%0d]: got wen=%b lat=%0d required %b 0", it, cap_wen, cap_lat, 4'b1 << way); end
      checks++; if (cap_idx !== idx || cap_tag !== tag) begin errors++; $display("[TB] FAIL rand_wr_addr[%0d]: got %0d/%h required %0d/%h", it, cap_idx, cap_tag, idx, tag); end
      if (!exp_err) begin
        checks++; if (cap_data !== exp_line) begin errors++; $display("[TB] FAIL rand_data[%0d]: got %h required %h", it, cap_data, exp_line); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_refill();
    test_ar_stall();
    test_slverr();
    test_early_rlast();
    test_overrun();
    test_foreign_id();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
